// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with valid/ready handshake, shift-add multiplier and an
// optional restoring divider, present when ALU_SEQ_DIV_EN is defined.
module alu_seq #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [DATA_WIDTH-1:0] IN_A,
  input  logic [DATA_WIDTH-1:0] IN_B,
  input  logic [3:0]            ALU_Op_Code,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  output logic [DATA_WIDTH-1:0] OUT_RESULT,
  output logic                  OUT_VALID,
  output logic [2:0]            OUT_FLAGS
);

  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned W1 = DATA_WIDTH + 1;
  localparam int unsigned CW = $clog2(DATA_WIDTH);

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_SHL  = 4'h3;
  localparam logic [3:0] OP_SHR  = 4'h4;
  localparam logic [3:0] OP_INCA = 4'h5;
  localparam logic [3:0] OP_INCB = 4'h6;
  localparam logic [3:0] OP_DECA = 4'h7;
  localparam logic [3:0] OP_DECB = 4'h8;
  localparam logic [3:0] OP_EQ   = 4'h9;
  localparam logic [3:0] OP_GT   = 4'hA;
  localparam logic [3:0] OP_LT   = 4'hB;
  localparam logic [3:0] OP_OR0  = 4'hC;
`ifdef ALU_SEQ_DIV_EN
  localparam logic [3:0] OP_DIV  = 4'hD;
  localparam logic [3:0] OP_REM  = 4'hE;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;
`else
  typedef enum logic [0:0] {S_IDLE, S_MUL} state_t;
`endif

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2*W-1:0]  prod;
  logic [W-1:0]    mcand;

  // Single-cycle datapath; bit W of sc_wide is the carry/borrow/shifted-out bit
  logic [W:0]   a_x;
  logic [W:0]   b_x;
  logic [W:0]   one_x;
  logic [W:0]   sc_wide;
  logic [W-1:0] sc_res;
  logic         sc_c;

  assign a_x   = {1'b0, IN_A};
  assign b_x   = {1'b0, IN_B};
  assign one_x = W1'(1);

  always_comb begin
    sc_wide = a_x;
    case (ALU_Op_Code)
      OP_ADD:  sc_wide = a_x + b_x;
      OP_SUB:  sc_wide = a_x - b_x;
      OP_SHL:  sc_wide = {IN_A, 1'b0};
      OP_SHR:  sc_wide = {IN_A[0], 1'b0, IN_A[W-1:1]};
      OP_INCA: sc_wide = a_x + one_x;
      OP_INCB: sc_wide = b_x + one_x;
      OP_DECA: sc_wide = a_x - one_x;
      OP_DECB: sc_wide = b_x - one_x;
      OP_EQ:   sc_wide = W1'(IN_A == IN_B);
      OP_GT:   sc_wide = W1'(IN_A > IN_B);
      OP_LT:   sc_wide = W1'(IN_A < IN_B);
      OP_OR0:  sc_wide = W1'(IN_A[0] | IN_B[0]);
      default: sc_wide = a_x;
    endcase
    sc_res = sc_wide[W-1:0];
    sc_c   = sc_wide[W];
  end

  // Shift-add step: prod holds {partial high half, remaining multiplier bits}
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_next;
  logic           last;

  always_comb begin
    mul_sum  = {1'b0, prod[2*W-1:W]};
    if (prod[0]) mul_sum = {1'b0, prod[2*W-1:W]} + {1'b0, mcand};
    mul_next = {mul_sum, prod[W-1:1]};
  end

  assign last = (cnt == CW'(W - 1));

`ifdef ALU_SEQ_DIV_EN
  logic [W-1:0] rem;
  logic [W-1:0] quo;
  logic [W-1:0] dvsr;
  logic         is_rem;
  logic [W:0]   div_shift;
  logic         div_ok;
  logic [W-1:0] rem_next;
  logic [W-1:0] quo_next;

  // Restoring step; a zero divisor always "fits", giving all-ones quotient and remainder A
  always_comb begin
    div_shift = {rem, quo[W-1]};
    div_ok    = (div_shift >= {1'b0, dvsr});
    rem_next  = div_shift[W-1:0];
    if (div_ok) rem_next = W'(div_shift - {1'b0, dvsr});
    quo_next  = {quo[W-2:0], div_ok};
  end
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= S_IDLE;
      IN_READY   <= 1'b1;
      OUT_RESULT <= '0;
      OUT_FLAGS  <= '0;
      OUT_VALID  <= 1'b0;
      cnt        <= '0;
      prod       <= '0;
      mcand      <= '0;
`ifdef ALU_SEQ_DIV_EN
      rem        <= '0;
      quo        <= '0;
      dvsr       <= '0;
      is_rem     <= 1'b0;
`endif
    end else begin
      OUT_VALID <= 1'b0;
      case (state)
        S_IDLE: begin
          if (IN_VALID && IN_READY) begin
            cnt <= '0;
            if (ALU_Op_Code == OP_MUL) begin
              state    <= S_MUL;
              IN_READY <= 1'b0;
              prod     <= {{W{1'b0}}, IN_B};
              mcand    <= IN_A;
            end
`ifdef ALU_SEQ_DIV_EN
            else if (ALU_Op_Code == OP_DIV || ALU_Op_Code == OP_REM) begin
              state    <= S_DIV;
              IN_READY <= 1'b0;
              rem      <= '0;
              quo      <= IN_A;
              dvsr     <= IN_B;
              is_rem   <= (ALU_Op_Code == OP_REM);
            end
`endif
            else begin
              OUT_RESULT <= sc_res;
              OUT_FLAGS  <= {1'b0, sc_c, ~|sc_res};
              OUT_VALID  <= 1'b1;
            end
          end
        end
        S_MUL: begin
          prod <= mul_next;
          cnt  <= cnt + CW'(1);
          if (last) begin
            state      <= S_IDLE;
            IN_READY   <= 1'b1;
            OUT_RESULT <= mul_next[W-1:0];
            OUT_FLAGS  <= {1'b0, |mul_next[2*W-1:W], ~|mul_next[W-1:0]};
            OUT_VALID  <= 1'b1;
          end
        end
`ifdef ALU_SEQ_DIV_EN
        S_DIV: begin
          rem <= rem_next;
          quo <= quo_next;
          cnt <= cnt + CW'(1);
          if (last) begin
            state      <= S_IDLE;
            IN_READY   <= 1'b1;
            OUT_RESULT <= is_rem ? rem_next : quo_next;
            OUT_FLAGS  <= {dvsr == '0, 1'b0, is_rem ? ~|rem_next : ~|quo_next};
            OUT_VALID  <= 1'b1;
          end
        end
`endif
        default: begin
          state    <= S_IDLE;
          IN_READY <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: scoreboard of expected {result, flags} checked on OUT_VALID,
// plus handshake/latency checks and a 16-bit instance for the wide multiply case.
`timescale 1ns/1ps
module tb_alu_seq;

  localparam int unsigned W   = 8;
  localparam int unsigned W16 = 16;

  logic           CLK = 1'b0;
  logic           RESET;
  logic [W-1:0]   IN_A, IN_B, OUT_RESULT;
  logic [3:0]     ALU_Op_Code;
  logic           IN_VALID, IN_READY, OUT_VALID;
  logic [2:0]     OUT_FLAGS;

  logic [W16-1:0] a16, b16, res16;
  logic [3:0]     op16;
  logic           v16, rdy16, vld16;
  logic [2:0]     flg16;

  int n_checks = 0;
  int n_pass   = 0;

  logic [W+2:0] exp_q[$];

  alu_seq #(.DATA_WIDTH(W)) u_dut (
    .CLK(CLK), .RESET(RESET), .IN_A(IN_A), .IN_B(IN_B), .ALU_Op_Code(ALU_Op_Code),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .OUT_RESULT(OUT_RESULT),
    .OUT_VALID(OUT_VALID), .OUT_FLAGS(OUT_FLAGS)
  );

  alu_seq #(.DATA_WIDTH(W16)) u_dut16 (
    .CLK(CLK), .RESET(RESET), .IN_A(a16), .IN_B(b16), .ALU_Op_Code(op16),
    .IN_VALID(v16), .IN_READY(rdy16), .OUT_RESULT(res16),
    .OUT_VALID(vld16), .OUT_FLAGS(flg16)
  );

  always #5 CLK = ~CLK;

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Scoreboard consumer
  always @(negedge CLK) begin
    if (OUT_VALID === 1'b1) begin
      chk("sb_expected_pending", 64'(exp_q.size() > 0), 64'(1));
      if (exp_q.size() > 0) chk("sb_result_flags", 64'({OUT_RESULT, OUT_FLAGS}), 64'(exp_q.pop_front()));
    end
  end

  // Present one operation at a negedge; returns at the negedge after the accept edge
  task automatic drive(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] er, input logic [2:0] ef, input bit push);
    IN_A = a; IN_B = b; ALU_Op_Code = op; IN_VALID = 1'b1;
    if (push) exp_q.push_back({er, ef});
    @(negedge CLK);
  endtask

  // Multi-cycle op: busy for n samples while unrelated inputs are offered, then one pulse
  task automatic check_multi(input string tag, input int n);
    int bad = 0;
    ALU_Op_Code = 4'h5; IN_A = 8'h33; IN_VALID = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge CLK);
      if (OUT_VALID !== 1'b0 || IN_READY !== 1'b0) bad++;
    end
    chk({tag, "_busy"}, 64'(bad), 64'(0));
    @(negedge CLK);
    IN_VALID = 1'b0;
    chk({tag, "_valid"}, 64'(OUT_VALID), 64'(1));
    chk({tag, "_ready"}, 64'(IN_READY), 64'(1));
    @(negedge CLK);
    chk({tag, "_pulse_end"}, 64'(OUT_VALID), 64'(0));
  endtask

  logic [3:0]   t_op [12] = '{4'h5, 4'h8, 4'h9, 4'h1, 4'h3, 4'h4, 4'h6, 4'h7, 4'hA, 4'hB, 4'hC, 4'hF};
  logic [W-1:0] t_a  [12] = '{8'hFF, 8'hFF, 8'hFF, 8'h05, 8'h81, 8'h81, 8'h00, 8'h00, 8'h05, 8'h05, 8'h02, 8'h3C};
  logic [W-1:0] t_b  [12] = '{8'h00, 8'h00, 8'h00, 8'h07, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h03, 8'h03, 8'h01, 8'h00};
  logic [W-1:0] t_r  [12] = '{8'h00, 8'hFF, 8'h00, 8'hFE, 8'h02, 8'h40, 8'h00, 8'hFF, 8'h01, 8'h00, 8'h01, 8'h3C};
  logic [2:0]   t_f  [12] = '{3'b011, 3'b010, 3'b001, 3'b010, 3'b010, 3'b010, 3'b011, 3'b010,
                              3'b000, 3'b001, 3'b000, 3'b000};

  initial begin
    int pulses;
    int bad;
    RESET = 1'b1; IN_A = '0; IN_B = '0; ALU_Op_Code = '0; IN_VALID = 1'b0;
    a16 = '0; b16 = '0; op16 = '0; v16 = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_result", 64'(OUT_RESULT), 64'(0));
    chk("rst_flags", 64'(OUT_FLAGS), 64'(0));
    chk("rst_valid", 64'(OUT_VALID), 64'(0));
    chk("rst_ready", 64'(IN_READY), 64'(1));
    RESET = 1'b0;

    // Single-cycle add with carry, latency 1
    drive(4'h0, 8'hF0, 8'h20, 8'h10, 3'b010, 1'b1);
    chk("add_latency", 64'(OUT_VALID), 64'(1));
    IN_VALID = 1'b0;
    @(negedge CLK);
    chk("add_one_pulse", 64'(OUT_VALID), 64'(0));

    // Multiplies
    drive(4'h2, 8'h0F, 8'h11, 8'hFF, 3'b000, 1'b1);
    check_multi("mul_ff", W);
    drive(4'h2, 8'h10, 8'h10, 8'h00, 3'b011, 1'b1);
    check_multi("mul_ovf", W);

`ifdef ALU_SEQ_DIV_EN
    drive(4'hD, 8'd200, 8'd7, 8'd28, 3'b000, 1'b1);
    check_multi("div", W);
    drive(4'hE, 8'd200, 8'd7, 8'd4, 3'b000, 1'b1);
    check_multi("rem", W);
    drive(4'hD, 8'h55, 8'h00, 8'hFF, 3'b100, 1'b1);
    check_multi("div_zero", W);
    drive(4'hE, 8'h55, 8'h00, 8'h55, 3'b100, 1'b1);
    check_multi("rem_zero", W);
`else
    drive(4'hD, 8'd9, 8'd0, 8'd9, 3'b000, 1'b1);
    chk("nodiv_d_latency", 64'(OUT_VALID), 64'(1));
    drive(4'hE, 8'd9, 8'd0, 8'd9, 3'b000, 1'b1);
    chk("nodiv_e_latency", 64'(OUT_VALID), 64'(1));
    IN_VALID = 1'b0;
    @(negedge CLK);
`endif

    // Back-to-back single-cycle ops, one accept per edge
    for (int i = 0; i < 12; i++) begin
      drive(t_op[i], t_a[i], t_b[i], t_r[i], t_f[i], 1'b1);
      chk("b2b_valid", 64'(OUT_VALID), 64'(1));
      chk("b2b_ready", 64'(IN_READY), 64'(1));
    end
    IN_VALID = 1'b0;
    @(negedge CLK);
    chk("b2b_end", 64'(OUT_VALID), 64'(0));

    // Reset in cycle k+3 of a multiply aborts it
    drive(4'h2, 8'h03, 8'h05, 8'h00, 3'b000, 1'b0);
    IN_VALID = 1'b0;
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    #1;
    chk("abort_result", 64'(OUT_RESULT), 64'(0));
    chk("abort_flags", 64'(OUT_FLAGS), 64'(0));
    chk("abort_valid", 64'(OUT_VALID), 64'(0));
    chk("abort_ready", 64'(IN_READY), 64'(1));
    @(negedge CLK);
    RESET = 1'b0;
    pulses = 0;
    for (int i = 0; i < int'(W) + 2; i++) begin
      @(negedge CLK);
      if (OUT_VALID === 1'b1) pulses++;
    end
    chk("abort_no_valid", 64'(pulses), 64'(0));
    drive(4'h0, 8'h01, 8'h01, 8'h02, 3'b000, 1'b1);
    chk("post_abort_valid", 64'(OUT_VALID), 64'(1));
    IN_VALID = 1'b0;
    @(negedge CLK);

    // 16-bit multiply overflow, result at edge k+16
    a16 = 16'h0100; b16 = 16'h0100; op16 = 4'h2; v16 = 1'b1;
    @(negedge CLK);
    v16 = 1'b0;
    bad = 0;
    for (int i = 0; i < int'(W16); i++) begin
      if (i > 0) @(negedge CLK);
      if (vld16 !== 1'b0 || rdy16 !== 1'b0) bad++;
    end
    chk("mul16_busy", 64'(bad), 64'(0));
    @(negedge CLK);
    chk("mul16_valid", 64'(vld16), 64'(1));
    chk("mul16_result", 64'(res16), 64'(16'h0000));
    chk("mul16_flags", 64'(flg16), 64'(3'b011));
    @(negedge CLK);
    chk("mul16_pulse_end", 64'(vld16), 64'(0));

    chk("sb_drained", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, sequential successor to the team's single-cycle 8-bit ALU for the FPGA microprocessor. Adds a valid/ready operand handshake, result and status flags, an iterative shift-add multiplier and an optional restoring divider. It sits between the processor's register file/bus controller and the writeback path. The controller must issue a new operation only when `IN_READY` is high and must capture the result on `OUT_VALID`.

## Interface
- `DATA_WIDTH`, default 8: operand and result width, 4..32.
- `CLK`  in  1  system clock, rising-edge.
- `RESET`  in  1  asynchronous, active-high reset.
- `IN_A`  in  DATA_WIDTH  operand A.
- `IN_B`  in  DATA_WIDTH  operand B.
- `ALU_Op_Code`  in  4  operation select.
- `IN_VALID`  in  1  operands and opcode valid this cycle.
- `IN_READY`  out  1  block can accept an operation.
- `OUT_RESULT`  out  DATA_WIDTH  registered result; holds until the next result.
- `OUT_VALID`  out  1  one-cycle pulse when `OUT_RESULT`/`OUT_FLAGS` update.
- `OUT_FLAGS`  out  3  {DZ, C, Z}; updates together with `OUT_RESULT`.

## Operation
- Accept: an operation is accepted on a rising edge where `IN_VALID && IN_READY`. Operands and opcode are latched on that edge. Inputs are ignored at all other times.
- Opcodes:
  - 0 A+B
  - 1 A−B
  - 2 A*B, low DATA_WIDTH bits
  - 3 A<<1
  - 4 A>>1 (logical)
  - 5 A+1
  - 6 B+1
  - 7 A−1
  - 8 B−1
  - 9 A==B
  - A A>B (unsigned)
  - B A<B (unsigned)
  - C A[0]|B[0]
  - D A/B (unsigned quotient)
  - E A%B (unsigned remainder)
  - F pass A
- Compare and OR opcodes (9, A, B, C) return 1 or 0, zero-extended.
- Z flag: result == 0, for all opcodes.
- C flag:
  - carry-out for 0, 5, 6;
  - borrow for 1, 7, 8;
  - bit shifted out for 3, 4;
  - high product half ≠ 0 for 2;
  - 0 otherwise.
- DZ flag: 1 only for opcode D or E with B == 0; 0 otherwise.
- Divide by zero:
  - opcode D returns all ones;
  - opcode E returns A.
- Arithmetic wraps modulo 2^DATA_WIDTH.
- State machine: IDLE, MUL, DIV.
  - IDLE: `IN_READY` = 1.
    - Single-cycle opcodes are computed and registered on the accept edge; the FSM stays in IDLE.
    - Opcode 2 goes to MUL.
    - Opcodes D/E go to DIV.
  - MUL: shift-add, one multiplier bit per cycle, DATA_WIDTH iterations. Returns to IDLE on the edge that registers the result.
  - DIV: restoring divide, one quotient bit per cycle, DATA_WIDTH iterations. Returns to IDLE on the edge that registers the result. Divide by zero still runs all iterations.
- `IN_READY` = 0 throughout MUL and DIV.

## Timing
- Accept edge is k.
- Single-cycle opcodes:
  - `OUT_VALID` is high in cycle k+1 (registered at edge k), latency 1.
  - Back-to-back accepts every cycle are supported.
- Opcodes 2, D, E:
  - result registered at edge k+DATA_WIDTH;
  - `OUT_VALID` high for the following cycle;
  - `IN_READY` low from after edge k until after edge k+DATA_WIDTH.
  - The earliest next accept is edge k+DATA_WIDTH+1.
- `OUT_VALID` is never high for two consecutive cycles from one operation.
- Reset values:
  - `OUT_RESULT` = 0
  - `OUT_FLAGS` = 0
  - `OUT_VALID` = 0
  - `IN_READY` = 1 (state IDLE)
  - all iteration counters and working registers 0
- Reset asserted mid-MUL/DIV: the operation is aborted immediately, with no `OUT_VALID`.
- After reset deasserts, the first accept is allowed on the next rising edge.

## Configuration
- `ALU_SEQ_DIV_EN` defined: the DIV state and divider datapath are present; opcodes D/E behave as above.
- Not defined:
  - no divider logic;
  - opcodes D/E execute as single-cycle pass A;
  - DZ is always 0;
  - the FSM has only IDLE and MUL.

## Test plan
- Opcode 0, A=0xF0, B=0x20 (W=8) -> `OUT_RESULT`=0x10, C=1, Z=0, `OUT_VALID` at k+1.
- Opcode 2, A=0x0F, B=0x11 -> 0xFF, C=0, `OUT_VALID` only at k+9 (edge k+8), `IN_READY`=0 for 8 cycles. Then A=0x10, B=0x10 -> 0x00, Z=1, C=1.
- With `ALU_SEQ_DIV_EN`:
  - opcode D, A=200, B=7 -> 28;
  - opcode E -> 4;
  - opcode D with B=0, A=0x55 -> 0xFF, DZ=1;
  - opcode E with B=0, A=0x55 -> 0x55, DZ=1.
- Back-to-back opcodes 5, 8, 9 with A=0xFF, B=0x00 on consecutive edges:
  - opcode 5 -> 0x00, Z=1, C=1;
  - opcode 8 -> 0xFF, C=1;
  - opcode 9 -> 0x00;
  - three consecutive `OUT_VALID` pulses.
- Assert `RESET` at cycle k+3 of a multiply -> all outputs 0, `IN_READY`=1, no `OUT_VALID`. A new opcode 0 (1+1) issued after release -> 2.
- DATA_WIDTH=16: opcode 2, A=0x0100, B=0x0100 -> 0x0000, C=1, Z=1 at k+17. Without the macro, opcode D, A=9 -> 9 at k+1.
